// File: rtl/inst_buffer_if.sv
// Fetch-side and decoder-side signal bundle of the instruction buffer.
// slave is the buffer; master is the fetch/decode environment driving it.
interface inst_buffer_if;
   logic                  flush;
   logic                  pause;
   logic [1:0]            fetch_valid;
   logic [1:0][31:0]      fetch_pc;
   logic [1:0][31:0]      fetch_inst;
   logic [1:0]            fetch_pre_is_branch;
   logic [1:0]            fetch_pre_is_branch_taken;
   logic [1:0][31:0]      fetch_pre_branch_addr;
   logic [1:0][5:0]       fetch_is_exception;
   logic [1:0][5:0][6:0]  fetch_exception_cause;
   logic [1:0][31:0]      pc;
   logic [1:0][31:0]      inst;
   logic [1:0]            pre_is_branch;
   logic [1:0]            pre_is_branch_taken;
   logic [1:0][31:0]      pre_branch_addr;
   logic [1:0][5:0]       is_exception;
   logic [1:0][5:0][6:0]  exception_cause;
   logic                  pause_buffer;

   modport slave (
      input  flush, pause, fetch_valid, fetch_pc, fetch_inst, fetch_pre_is_branch,
             fetch_pre_is_branch_taken, fetch_pre_branch_addr, fetch_is_exception,
             fetch_exception_cause,
      output pc, inst, pre_is_branch, pre_is_branch_taken, pre_branch_addr,
             is_exception, exception_cause, pause_buffer
   );

   modport master (
      output flush, pause, fetch_valid, fetch_pc, fetch_inst, fetch_pre_is_branch,
             fetch_pre_is_branch_taken, fetch_pre_branch_addr, fetch_is_exception,
             fetch_exception_cause,
      input  pc, inst, pre_is_branch, pre_is_branch_taken, pre_branch_addr,
             is_exception, exception_cause, pause_buffer
   );
endinterface

// File: rtl/inst_buffer.sv
// Circular instruction queue between fetch and decode with registered output slots.
// Optional feature macro INST_BUFFER_BYPASS_EN: fetch slots go straight to the output slots when the queue is nearly empty.
module inst_buffer #(
   parameter int DEPTH         = 16,
   parameter int DECODER_WIDTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   inst_buffer_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [31:0]     pc;
      logic [31:0]     inst;
      logic            pre_is_branch;
      logic            pre_is_branch_taken;
      logic [31:0]     pre_branch_addr;
      logic [5:0]      is_exception;
      logic [5:0][6:0] exception_cause;
   } entry_t;

   entry_t                   mem     [DEPTH];
   logic [PW-1:0]            head, tail;
   logic [CW-1:0]            count, free;
   entry_t                   fetch_e [DECODER_WIDTH];
   entry_t                   cmp_e   [DECODER_WIDTH];
   entry_t                   push_e  [DECODER_WIDTH];
   entry_t                   slot_p0 [DECODER_WIDTH];
   entry_t                   slot_p1 [DECODER_WIDTH];
   logic [DECODER_WIDTH-1:0] vld_p0;
   logic [1:0]               n_fetch, n_byp, n_req, n_push, n_pop;
   logic [2:0]               n_out;

   always_comb begin
      for (int i = 0; i < DECODER_WIDTH; i++) begin
         fetch_e[i].pc                  = bus.fetch_pc[i];
         fetch_e[i].inst                = bus.fetch_inst[i];
         fetch_e[i].pre_is_branch       = bus.fetch_pre_is_branch[i];
         fetch_e[i].pre_is_branch_taken = bus.fetch_pre_is_branch_taken[i];
         fetch_e[i].pre_branch_addr     = bus.fetch_pre_branch_addr[i];
         fetch_e[i].is_exception        = bus.fetch_is_exception[i];
         fetch_e[i].exception_cause     = bus.fetch_exception_cause[i];
      end
   end

   // Pops only see entries present at the start of the cycle; pushes are clipped to free space.
   always_comb begin
      free    = CW'(DEPTH) - count;
      n_fetch = {1'b0, bus.fetch_valid[0]} + {1'b0, bus.fetch_valid[1]};
      n_pop   = 2'd0;
      if (!bus.pause) n_pop = (count >= CW'(2)) ? 2'd2 : count[1:0];
      n_byp   = 2'd0;
`ifdef INST_BUFFER_BYPASS_EN
      if (!bus.pause && count == '0) n_byp = n_fetch;
      else if (!bus.pause && count == CW'(1) && n_fetch != 2'd0) n_byp = 2'd1;
`endif
      n_req   = n_fetch - n_byp;
      n_push  = (CW'(n_req) > free) ? free[1:0] : n_req;
      n_out   = {1'b0, n_pop} + {1'b0, n_byp};
   end

   always_comb begin
      cmp_e[0]  = bus.fetch_valid[0] ? fetch_e[0] : fetch_e[1];
      cmp_e[1]  = fetch_e[1];
      push_e[0] = (n_byp == 2'd1) ? cmp_e[1] : cmp_e[0];
      push_e[1] = cmp_e[1];
      vld_p0[0] = n_out >= 3'd1;
      vld_p0[1] = n_out >= 3'd2;
      slot_p0[0] = (n_pop != 2'd0) ? mem[head] : cmp_e[0];
      case (n_pop)
         2'd2:    slot_p0[1] = mem[head + PW'(1)];
         2'd1:    slot_p0[1] = cmp_e[0];
         default: slot_p0[1] = cmp_e[1];
      endcase
      for (int i = 0; i < DECODER_WIDTH; i++)
         if (!vld_p0[i]) slot_p0[i] = '0;
   end

   // p0 -> p1: queue pointers and registered output slots
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DECODER_WIDTH; i++) slot_p1[i] <= '0;
      end else if (bus.flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DECODER_WIDTH; i++) slot_p1[i] <= '0;
      end else begin
         head  <= head + PW'(n_pop);
         tail  <= tail + PW'(n_push);
         count <= count + CW'(n_push) - CW'(n_pop);
         if (!bus.pause)
            for (int i = 0; i < DECODER_WIDTH; i++) slot_p1[i] <= slot_p0[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst && !bus.flush) begin
         if (n_push != 2'd0) mem[tail] <= push_e[0];
         if (n_push == 2'd2) mem[tail + PW'(1)] <= push_e[1];
         assert (CW'(n_req) <= free)
            else $error("inst_buffer: fetch overflow, valid slots dropped");
      end
   end

   for (genvar g = 0; g < DECODER_WIDTH; g++) begin : g_out
      assign bus.pc[g]                  = slot_p1[g].pc;
      assign bus.inst[g]                = slot_p1[g].inst;
      assign bus.pre_is_branch[g]       = slot_p1[g].pre_is_branch;
      assign bus.pre_is_branch_taken[g] = slot_p1[g].pre_is_branch_taken;
      assign bus.pre_branch_addr[g]     = slot_p1[g].pre_branch_addr;
      assign bus.is_exception[g]        = slot_p1[g].is_exception;
      assign bus.exception_cause[g]     = slot_p1[g].exception_cause;
   end

   assign bus.pause_buffer = free < CW'(2);
endmodule
